// File: rtl/cosmic_pkg.sv
// Shared constants and types for the tone-generation path: note codes,
// base pitch table, octave encodings and the player state enum.
package cosmic_pkg;

  localparam logic [3:0] NOTE_NONE = 4'd0;
  localparam logic [3:0] NOTE_C    = 4'd1;
  localparam logic [3:0] NOTE_D    = 4'd2;
  localparam logic [3:0] NOTE_E    = 4'd3;
  localparam logic [3:0] NOTE_F    = 4'd4;
  localparam logic [3:0] NOTE_G    = 4'd5;
  localparam logic [3:0] NOTE_A    = 4'd6;
  localparam logic [3:0] NOTE_B    = 4'd7;

  localparam int NUM_NOTES = 7;

  // Base-octave (C4..B4) frequencies in centi-Hz, indexed by note code - 1.
  localparam int unsigned FREQ_CHZ [NUM_NOTES] = '{
    26163, 29366, 32963, 34923, 39200, 44000, 49388
  };

  localparam logic [1:0] OCT_DOWN = 2'd0;
  localparam logic [1:0] OCT_BASE = 2'd1;
  localparam logic [1:0] OCT_UP1  = 2'd2;
  localparam logic [1:0] OCT_UP2  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Codes 8-15 are treated exactly like silence.
  function automatic logic note_valid(input logic [3:0] note, input logic mute);
    return !mute && (note != NOTE_NONE) && (note <= NOTE_B);
  endfunction

endpackage

// File: rtl/note_player_if.sv
// Note request / tone status bundle between the keyboard side and the player.
interface note_player_if;
  logic [3:0] note_in;
  logic [1:0] octave;
  logic       mute;
  logic       buzzer;
  logic       playing;
  logic [3:0] cur_note;

  modport master (
    output note_in, octave, mute,
    input  buzzer, playing, cur_note
  );

  modport slave (
    input  note_in, octave, mute,
    output buzzer, playing, cur_note
  );
endinterface

// File: rtl/note_period_rom.sv
// Combinational lookup of the octave-scaled half period (in clock cycles)
// for a note code; all divisions are folded into constants at elaboration.
module note_period_rom
  import cosmic_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int          CNT_W  = 22
) (
  input  logic [3:0]       note,
  input  logic [1:0]       octave,
  output logic [CNT_W-1:0] hp
);

  logic [CNT_W-1:0] base_tab [8];
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] scaled;

  // Entry 0 is never used for a sounding note; it just keeps the output sane.
  assign base_tab[0] = CNT_W'(1);

  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_tab
      localparam logic [63:0] HP_FULL =
        (64'(CLK_HZ) * 64'd50) / 64'(FREQ_CHZ[gi-1]);
      assign base_tab[gi] = HP_FULL[CNT_W-1:0];
    end
  endgenerate

  always_comb begin
    base   = (note[3] == 1'b0) ? base_tab[note[2:0]] : CNT_W'(1);
    scaled = base;
    case (octave)
      OCT_DOWN: scaled = base << 1;
      OCT_BASE: scaled = base;
      OCT_UP1:  scaled = base >> 1;
      OCT_UP2:  scaled = base >> 2;
      default:  scaled = base;
    endcase
    hp = (scaled == '0) ? CNT_W'(1) : scaled;
  end

endmodule

// File: rtl/note_player.sv
// Square-wave tone generator: registers the note request, plays it at the
// looked-up pitch and inserts a fixed silence gap between distinct notes.
module note_player
  import cosmic_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned GAP_CYCLES = 1_000_000,
  parameter int          CNT_W      = 22
) (
  input  logic          clk,
  input  logic          rst_n,
  note_player_if.slave  bus
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [3:0]       note_q;
  logic [1:0]       oct_q;
  logic             mute_q;

  state_t           state_reg, state_next;
  logic [3:0]       cur_note_reg, cur_note_next;
  logic [1:0]       cur_oct_reg, cur_oct_next;
  logic [CNT_W-1:0] hp_reg, hp_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic             buzzer_reg, buzzer_next;

  logic [CNT_W-1:0] rom_hp;
  logic             eff_valid;
  logic             changed;
  logic             gap_done;
  logic             half_done;

  note_period_rom #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W)
  ) u_rom (
    .note   (note_q),
    .octave (oct_q),
    .hp     (rom_hp)
  );

  assign eff_valid = note_valid(note_q, mute_q);
  assign changed   = (note_q != cur_note_reg) || (oct_q != cur_oct_reg);
  assign gap_done  = (32'(gap_cnt_reg) == (GAP_CYCLES - 32'd1));
  assign half_done = (cnt_reg == (hp_reg - CNT_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_q       <= NOTE_NONE;
      oct_q        <= '0;
      mute_q       <= 1'b0;
      state_reg    <= ST_IDLE;
      cur_note_reg <= NOTE_NONE;
      cur_oct_reg  <= '0;
      hp_reg       <= '0;
      cnt_reg      <= '0;
      gap_cnt_reg  <= '0;
      buzzer_reg   <= 1'b0;
    end else begin
      note_q       <= bus.note_in;
      oct_q        <= bus.octave;
      mute_q       <= bus.mute;
      state_reg    <= state_next;
      cur_note_reg <= cur_note_next;
      cur_oct_reg  <= cur_oct_next;
      hp_reg       <= hp_next;
      cnt_reg      <= cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      buzzer_reg   <= buzzer_next;
    end
  end

  // Invalid always wins over a change, so release never passes through GAP.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (eff_valid) state_next = ST_PLAY;
      ST_PLAY: begin
        if (!eff_valid)   state_next = ST_IDLE;
        else if (changed) state_next = ST_GAP;
      end
      ST_GAP: begin
        if (!eff_valid)    state_next = ST_IDLE;
        else if (gap_done) state_next = ST_PLAY;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_note_next = cur_note_reg;
    cur_oct_next  = cur_oct_reg;
    hp_next       = hp_reg;
    cnt_next      = '0;
    gap_cnt_next  = '0;
    buzzer_next   = 1'b0;

    if (state_next == ST_PLAY) begin
      if (state_reg == ST_PLAY) begin
        // Steady tone: pitch stays latched, only the phase counter runs.
        if (half_done) begin
          buzzer_next = ~buzzer_reg;
          cnt_next    = '0;
        end else begin
          buzzer_next = buzzer_reg;
          cnt_next    = cnt_reg + CNT_W'(1);
        end
      end else begin
        cur_note_next = note_q;
        cur_oct_next  = oct_q;
        hp_next       = rom_hp;
        buzzer_next   = 1'b1;
      end
    end else if (state_next == ST_GAP && state_reg == ST_GAP) begin
      gap_cnt_next = gap_cnt_reg + GAP_W'(1);
    end
  end

  assign bus.buzzer   = buzzer_reg;
  assign bus.playing  = (state_reg == ST_PLAY);
  assign bus.cur_note = (state_reg == ST_PLAY) ? cur_note_reg : NOTE_NONE;

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: directed scenarios plus randomized
// notes/octaves checked against pitch and gap rules computed in the bench.
module tb_note_player;

  localparam int unsigned CLK_HZ     = 1_000_000;
  localparam int unsigned GAP_CYCLES = 50;
  localparam int          RUN_LIMIT  = 10000;
  localparam int          FREQ [7]   = '{26163, 29366, 32963, 34923, 39200, 44000, 49388};

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  note_player_if bus();

  note_player #(
    .CLK_HZ     (CLK_HZ),
    .GAP_CYCLES (GAP_CYCLES),
    .CNT_W      (22)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Half period from the pitch rules: floor(CLK_HZ*50/freq), octave scaled, min 1.
  function automatic int ref_hp(input int note, input int oct);
    longint base;
    int     hp;
    base = (longint'(CLK_HZ) * 50) / FREQ[note-1];
    case (oct)
      0:       hp = int'(base * 2);
      1:       hp = int'(base);
      2:       hp = int'(base / 2);
      default: hp = int'(base / 4);
    endcase
    return (hp < 1) ? 1 : hp;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Number of consecutive samples (starting now) at which buzzer equals lvl.
  task automatic run_len(input logic lvl, output int len);
    len = 0;
    while (bus.buzzer === lvl && len < RUN_LIMIT) begin
      len++;
      tick();
    end
  endtask

  task automatic go_idle();
    bus.note_in = 4'd0;
    bus.mute    = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.note_in = 4'd0;
    bus.octave  = 2'd1;
    bus.mute    = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus.buzzer !== 1'b0) begin n_fail++; $display("FAIL reset_buzzer: got %b want 0", bus.buzzer); end
    n_checks++; if (bus.playing !== 1'b0) begin n_fail++; $display("FAIL reset_playing: got %b want 0", bus.playing); end
    n_checks++; if (bus.cur_note !== 4'd0) begin n_fail++; $display("FAIL reset_cur_note: got %0d want 0", bus.cur_note); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.playing !== 1'b0) begin n_fail++; $display("FAIL reset_idle_after_release: got %b want 0", bus.playing); end
    $display("test_reset: done");
  endtask

  task automatic test_basic_tone();
    int len;
    int hp;
    hp = ref_hp(6, 1);
    go_idle();
    bus.note_in = 4'd6;
    bus.octave  = 2'd1;
    tick();
    n_checks++; if (bus.playing !== 1'b0) begin n_fail++; $display("FAIL basic_latency1: playing got %b want 0", bus.playing); end
    tick();
    n_checks++; if (bus.playing !== 1'b1) begin n_fail++; $display("FAIL basic_playing: got %b want 1", bus.playing); end
    n_checks++; if (bus.cur_note !== 4'd6) begin n_fail++; $display("FAIL basic_cur_note: got %0d want 6", bus.cur_note); end
    run_len(1'b1, len);
    n_checks++; if (len !== hp) begin n_fail++; $display("FAIL basic_high1: got %0d want %0d", len, hp); end
    run_len(1'b0, len);
    n_checks++; if (len !== hp) begin n_fail++; $display("FAIL basic_low1: got %0d want %0d", len, hp); end
    run_len(1'b1, len);
    n_checks++; if (len !== hp) begin n_fail++; $display("FAIL basic_high2: got %0d want %0d", len, hp); end
    $display("test_basic_tone: note=6 oct=1 hp=%0d", hp);
  endtask

  task automatic test_octave_change();
    int len;
    go_idle();
    bus.note_in = 4'd1;
    bus.octave  = 2'd0;
    tick(); tick();
    run_len(1'b1, len);
    n_checks++; if (len !== ref_hp(1, 0)) begin n_fail++; $display("FAIL oct_high_o0: got %0d want %0d", len, ref_hp(1, 0)); end
    run_len(1'b0, len);
    n_checks++; if (len !== ref_hp(1, 0)) begin n_fail++; $display("FAIL oct_low_o0: got %0d want %0d", len, ref_hp(1, 0)); end
    bus.octave = 2'd3;
    tick();
    n_checks++; if (bus.buzzer !== 1'b1) begin n_fail++; $display("FAIL oct_old_tone_held: got %b want 1", bus.buzzer); end
    tick();
    n_checks++; if (bus.playing !== 1'b0) begin n_fail++; $display("FAIL oct_gap_entry: playing got %b want 0", bus.playing); end
    run_len(1'b0, len);
    n_checks++; if (len !== int'(GAP_CYCLES)) begin n_fail++; $display("FAIL oct_gap_len: got %0d want %0d", len, GAP_CYCLES); end
    n_checks++; if (bus.cur_note !== 4'd1) begin n_fail++; $display("FAIL oct_cur_note: got %0d want 1", bus.cur_note); end
    run_len(1'b1, len);
    n_checks++; if (len !== ref_hp(1, 3)) begin n_fail++; $display("FAIL oct_high_o3: got %0d want %0d", len, ref_hp(1, 3)); end
    run_len(1'b0, len);
    n_checks++; if (len !== ref_hp(1, 3)) begin n_fail++; $display("FAIL oct_low_o3: got %0d want %0d", len, ref_hp(1, 3)); end
    $display("test_octave_change: note=1 oct 0->3 hp %0d->%0d", ref_hp(1, 0), ref_hp(1, 3));
  endtask

  task automatic test_note_change();
    int len;
    go_idle();
    bus.note_in = 4'd3;
    bus.octave  = 2'd1;
    tick(); tick();
    run_len(1'b1, len);
    n_checks++; if (len !== ref_hp(3, 1)) begin n_fail++; $display("FAIL chg_high_n3: got %0d want %0d", len, ref_hp(3, 1)); end
    bus.note_in = 4'd5;
    tick(); tick();
    n_checks++; if (bus.cur_note !== 4'd0) begin n_fail++; $display("FAIL chg_gap_cur_note: got %0d want 0", bus.cur_note); end
    run_len(1'b0, len);
    n_checks++; if (len !== int'(GAP_CYCLES)) begin n_fail++; $display("FAIL chg_gap_len: got %0d want %0d", len, GAP_CYCLES); end
    n_checks++; if (bus.cur_note !== 4'd5) begin n_fail++; $display("FAIL chg_cur_note: got %0d want 5", bus.cur_note); end
    run_len(1'b1, len);
    n_checks++; if (len !== ref_hp(5, 1)) begin n_fail++; $display("FAIL chg_high_n5: got %0d want %0d", len, ref_hp(5, 1)); end
    $display("test_note_change: note 3->5 hp=%0d", ref_hp(5, 1));
  endtask

  task automatic test_gap_abort();
    int act;
    go_idle();
    bus.note_in = 4'd2;
    bus.octave  = 2'd1;
    tick(); tick();
    bus.note_in = 4'd7;
    tick(); tick();
    repeat (10) tick();
    bus.note_in = 4'd0;
    tick(); tick();
    n_checks++; if (bus.cur_note !== 4'd0) begin n_fail++; $display("FAIL abort_cur_note: got %0d want 0", bus.cur_note); end
    act = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.buzzer !== 1'b0 || bus.playing !== 1'b0) act++;
      tick();
    end
    n_checks++; if (act !== 0) begin n_fail++; $display("FAIL abort_no_replay: active samples got %0d want 0", act); end
    $display("test_gap_abort: gap cancelled by silence");
  endtask

  task automatic test_invalid_mute();
    int act;
    int len;
    go_idle();
    bus.note_in = 4'd12;
    bus.octave  = 2'd1;
    act = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.buzzer !== 1'b0 || bus.playing !== 1'b0) act++;
      tick();
    end
    n_checks++; if (act !== 0) begin n_fail++; $display("FAIL invalid_code_silent: active samples got %0d want 0", act); end
    bus.note_in = 4'd4;
    bus.mute    = 1'b1;
    act = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.buzzer !== 1'b0 || bus.playing !== 1'b0) act++;
      tick();
    end
    n_checks++; if (act !== 0) begin n_fail++; $display("FAIL mute_silent: active samples got %0d want 0", act); end
    bus.mute = 1'b0;
    tick();
    n_checks++; if (bus.playing !== 1'b0) begin n_fail++; $display("FAIL unmute_latency: playing got %b want 0", bus.playing); end
    tick();
    n_checks++; if (bus.cur_note !== 4'd4) begin n_fail++; $display("FAIL unmute_cur_note: got %0d want 4", bus.cur_note); end
    run_len(1'b1, len);
    n_checks++; if (len !== ref_hp(4, 1)) begin n_fail++; $display("FAIL unmute_high: got %0d want %0d", len, ref_hp(4, 1)); end
    $display("test_invalid_mute: note 12 / muted 4 silent, unmuted hp=%0d", ref_hp(4, 1));
  endtask

  task automatic test_async_reset();
    int len;
    go_idle();
    bus.note_in = 4'd2;
    bus.octave  = 2'd1;
    tick(); tick();
    repeat (5) tick();
    n_checks++; if (bus.buzzer !== 1'b1) begin n_fail++; $display("FAIL areset_pre_high: got %b want 1", bus.buzzer); end
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.buzzer !== 1'b0) begin n_fail++; $display("FAIL areset_buzzer: got %b want 0", bus.buzzer); end
    n_checks++; if (bus.playing !== 1'b0) begin n_fail++; $display("FAIL areset_playing: got %b want 0", bus.playing); end
    n_checks++; if (bus.cur_note !== 4'd0) begin n_fail++; $display("FAIL areset_cur_note: got %0d want 0", bus.cur_note); end
    #3 rst_n = 1'b1;
    tick();
    n_checks++; if (bus.playing !== 1'b0) begin n_fail++; $display("FAIL areset_resume_latency: playing got %b want 0", bus.playing); end
    tick();
    n_checks++; if (bus.playing !== 1'b1 || bus.cur_note !== 4'd2) begin
      n_fail++; $display("FAIL areset_resume: playing=%b cur_note=%0d want 1/2", bus.playing, bus.cur_note);
    end
    run_len(1'b1, len);
    n_checks++; if (len !== ref_hp(2, 1)) begin n_fail++; $display("FAIL areset_resume_high: got %0d want %0d", len, ref_hp(2, 1)); end
    $display("test_async_reset: resumed note 2 hp=%0d", ref_hp(2, 1));
  endtask

  task automatic test_random_tones();
    int n, o, len, hp;
    for (int it = 0; it < 4; it++) begin
      n  = int'($urandom_range(1, 7));
      o  = int'($urandom_range(0, 3));
      hp = ref_hp(n, o);
      go_idle();
      bus.note_in = 4'(n);
      bus.octave  = 2'(o);
      tick(); tick();
      n_checks++; if (bus.cur_note !== 4'(n)) begin n_fail++; $display("FAIL rand_cur_note: got %0d want %0d", bus.cur_note, n); end
      run_len(1'b1, len);
      n_checks++; if (len !== hp) begin n_fail++; $display("FAIL rand_high n=%0d o=%0d: got %0d want %0d", n, o, len, hp); end
      run_len(1'b0, len);
      n_checks++; if (len !== hp) begin n_fail++; $display("FAIL rand_low n=%0d o=%0d: got %0d want %0d", n, o, len, hp); end
      $display("test_random_tones: note=%0d oct=%0d hp=%0d", n, o, hp);
    end
  endtask

  task automatic test_back_to_back();
    int a, b, c, oa, oc, k, len;
    for (int it = 0; it < 3; it++) begin
      a  = int'($urandom_range(1, 7));
      b  = (a % 7) + 1 + int'($urandom_range(0, 5));
      if (b > 7) b -= 7;
      c  = int'($urandom_range(1, 7));
      oa = int'($urandom_range(0, 3));
      oc = int'($urandom_range(0, 3));
      k  = int'($urandom_range(5, 40));
      go_idle();
      bus.note_in = 4'(a);
      bus.octave  = 2'(oa);
      tick(); tick(); tick();
      bus.note_in = 4'(b);
      tick(); tick();
      len = 0;
      while (bus.buzzer === 1'b0 && len < RUN_LIMIT) begin
        if (len == k) begin
          bus.note_in = 4'(c);
          bus.octave  = 2'(oc);
        end
        len++;
        tick();
      end
      n_checks++; if (len !== int'(GAP_CYCLES)) begin n_fail++; $display("FAIL b2b_gap_len: got %0d want %0d", len, GAP_CYCLES); end
      n_checks++; if (bus.cur_note !== 4'(c)) begin n_fail++; $display("FAIL b2b_cur_note: got %0d want %0d", bus.cur_note, c); end
      run_len(1'b1, len);
      n_checks++; if (len !== ref_hp(c, oc)) begin n_fail++; $display("FAIL b2b_high: got %0d want %0d", len, ref_hp(c, oc)); end
      $display("test_back_to_back: %0d -> %0d -> %0d (oct %0d) at gap cycle %0d", a, b, c, oc, k);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_tone();
    test_octave_change();
    test_note_change();
    test_gap_abort();
    test_invalid_mute();
    test_async_reset();
    test_random_tones();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/note_player.md
# note_player

Tone-generation stage directly downstream of the keyboard note mapper. Consumes the 4-bit note code (0 = silence, 1–7 = C through B) plus an octave select. Drives a square-wave buzzer output at the note's pitch. Inserts a short silence gap on every note-to-note change so consecutive notes articulate and don't glitch.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency in Hz.
- `GAP_CYCLES`, 1_000_000, length of the inter-note silence in clock cycles (≥1).
- `CNT_W`, 22, width of the half-period counter. Must hold the largest half period (note 1, octave 0).

Ports:
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `note_in` input 4: note code from the mapper. 0 = silence, 1–7 = notes, 8–15 = treated as silence.
- `octave` input 2: 0 = one octave down, 1 = base octave (C4–B4), 2 = one octave up, 3 = two octaves up.
- `mute` input 1: 1 forces silence, same as `note_in` = 0.
- `buzzer` output 1: square-wave audio output.
- `playing` output 1: high while in state PLAY.
- `cur_note` output 4: note currently sounding, 0 when not in PLAY.

## Operation
- Input stage: `note_in`, `octave` and `mute` are registered once into `note_q`, `oct_q`, `mute_q`. The FSM acts only on the registered values. An effective note is valid when `mute_q` = 0 and `note_q` is in 1–7.
- Base frequencies in centi-Hz, notes 1–7: 26163, 29366, 32963, 34923, 39200, 44000, 49388.
- Base half period: `hp = (CLK_HZ*50) / freq_chz`, integer floor.
- Octave scaling of `hp`:
  - octave 0: `hp<<1`
  - octave 1: `hp`
  - octave 2: `hp>>1`
  - octave 3: `hp>>2`
  - A scaled result of 0 is clamped to 1.
- FSM states IDLE, PLAY, GAP:
  - IDLE: `buzzer`=0, counter=0. On a valid note → PLAY; load `cur_note`/octave; `buzzer`=1; counter=0.
  - PLAY: counter increments each cycle. When counter = scaled `hp`−1, toggle `buzzer` and clear the counter.
    - Effective note becomes invalid → IDLE.
    - Note or octave changes to another valid value → GAP; counter=0.
    - Otherwise stay in PLAY.
  - GAP: `buzzer`=0; counter counts to `GAP_CYCLES`−1.
    - Effective note becomes invalid → IDLE immediately.
    - Counter expires with a valid note → PLAY using the note/octave present at expiry; `buzzer`=1; counter=0.
    - Note changes during GAP do not restart the gap.
- Invalid takes priority over change: a change straight to 0, 8–15, or mute goes to IDLE, not GAP.
- Reset values: state IDLE, `buzzer`=0, `playing`=0, `cur_note`=0, all counters and input registers 0. Async reset mid-tone silences `buzzer` immediately.

## Timing
- Latency: `note_in` set before edge k is captured into `note_q` at edge k. The FSM enters PLAY at edge k+1, so `buzzer`=1, `playing`=1 and `cur_note` valid from edge k+1.
- Square wave: exactly `hp_scaled` cycles high then `hp_scaled` cycles low; period 2×`hp_scaled`; duty 50 %.
- Release: the note goes invalid before edge k → `buzzer`=0 and `playing`=0 from edge k+1.
- Note change: new value captured at edge k; GAP entered at edge k+1 with `buzzer`=0. PLAY re-entered `GAP_CYCLES` cycles after GAP entry, with `buzzer`=1.
- The pitch of a sounding note is held constant; the period is recomputed only on entry to PLAY.

## Structure
- Shared package `cosmic_pkg` holds:
  - note code constants NOTE_NONE=0 … NOTE_B=7;
  - the 7-entry centi-Hz frequency constant array;
  - octave encoding constants;
  - the state enum typedef.
- Sub-module `note_period_rom`: combinational; inputs (note, octave) → scaled half period; parameterized by `CLK_HZ` and `CNT_W`. The FSM and counters stay in `note_player`.

## Test plan
Simulation uses `CLK_HZ`=1_000_000 and `GAP_CYCLES`=50.
- Reset, then `note_in`=6, `octave`=1 → `buzzer` high 1136 cycles, low 1136 cycles, repeating; `playing`=1 and `cur_note`=6 two edges after the input change.
- `note_in`=1 with `octave`=0, then `octave`=3 → half period 3822 cycles; after the 50-cycle gap, half period 477 cycles.
- PLAY note 3, switch to note 5 → `buzzer`=0 for exactly 50 cycles, then rises with half period 1275; `cur_note`=5.
- During GAP, drive `note_in`=0 → IDLE next edge; `buzzer`=0; `cur_note`=0; no PLAY re-entry.
- `note_in`=12, then `note_in`=4 with `mute`=1 → `buzzer` stays 0 and `playing`=0. Deassert `mute` → PLAY with half period 1431.
- Assert `rst_n`=0 mid high phase → `buzzer`, `playing`, `cur_note` drop to 0 without waiting for a clock edge. Release with note 2 held → PLAY resumes 2 edges later.
